// File: rtl/div_32.sv
// Multi-cycle restoring shift-subtract divider: one quotient bit per clock, quotient to LO, remainder to HI.
// Define DIV_SIGNED_EN for two's-complement signed division; the default build is unsigned.
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on acceptance
  // CALC  | one shift-subtract step per clock, counter runs WIDTH..1
  // DONE  | results valid, done pulses for this single cycle
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem, dq, dvs;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] prem_nx, dq_nx;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  always_comb begin
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fix = neg_q ? -dq_nx : dq_nx;
    r_fix = neg_r ? -prem_nx : prem_nx;
  end
`else
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fix = dq_nx;
    r_fix = prem_nx;
  end
`endif

  // Partial remainder needs one extra bit after the shift; the sign of the
  // WIDTH+1 bit trial difference decides the quotient bit.
  always_comb begin
    rem_sh = {prem, dq[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs};
    if (!trial[WIDTH]) begin
      prem_nx = trial[WIDTH-1:0];
      dq_nx   = {dq[WIDTH-2:0], 1'b1};
    end else begin
      prem_nx = rem_sh[WIDTH-1:0];
      dq_nx   = {dq[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt       <= '0;
      prem      <= '0;
      dq        <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt      <= CW'(WIDTH);
          prem     <= '0;
          dq       <= a_mag;
          dvs      <= b_mag;
          div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
          neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r    <= dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend;
            div_zero  <= 1'b1;
          end
        end
        CALC: begin
          prem <= prem_nx;
          dq   <= dq_nx;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
